// File: rtl/song_sequencer_ctrl.sv
// Note-ROM driven melody sequencer: fetches one entry per note, holds it for a
// programmed number of beats, inserts a silent gap, and drives the tone divider.
module song_sequencer_ctrl #(
    parameter int TICKS_PER_BEAT = 12500000,
    parameter int GAP_TICKS      = 625000,
    parameter int ADDR_W         = 8,
    parameter int DIV_W          = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] song_base,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [5:0]        rom_data,
    output logic [DIV_W-1:0]  clkdivider,
    output logic [3:0]        note_code,
    output logic              busy,
    output logic              done
);

    // state  | meaning
    // IDLE   | waiting for start
    // FETCH  | rom_addr presented, waiting one cycle for ROM data
    // LOAD   | decode ROM word: note/rest -> PLAY, end marker -> FETCH (loop) or DONE
    // PLAY   | note sounding, beat and tick down-counters running
    // GAP    | silence between notes, then advance to next entry
    // DONE   | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    localparam int TICK_MAX = (TICKS_PER_BEAT > GAP_TICKS) ? TICKS_PER_BEAT : GAP_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);

    localparam logic [TICK_W-1:0] BEAT_RELOAD = TICK_W'(TICKS_PER_BEAT - 1);
    localparam logic [TICK_W-1:0] GAP_RELOAD  = TICK_W'(GAP_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_ONE    = TICK_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
    localparam logic [3:0]        CODE_SILENT = 4'd12;
    localparam logic [3:0]        CODE_END    = 4'd15;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DIV_W-1:0]    clkdivider_q, clkdivider_d;
    logic [3:0]          note_code_q, note_code_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [1:0]          beats_q, beats_d;
    logic [TICK_W-1:0]   tick_q, tick_d;

    function automatic logic [DIV_W-1:0] note_div(input logic [3:0] code);
        logic [DIV_W-1:0] div;
        case (code)
            4'd0:    div = DIV_W'(95556);
            4'd1:    div = DIV_W'(90194);
            4'd2:    div = DIV_W'(85131);
            4'd3:    div = DIV_W'(80353);
            4'd4:    div = DIV_W'(75843);
            4'd5:    div = DIV_W'(71586);
            4'd6:    div = DIV_W'(67568);
            4'd7:    div = DIV_W'(63776);
            4'd8:    div = DIV_W'(60197);
            4'd9:    div = DIV_W'(56818);
            4'd10:   div = DIV_W'(53629);
            4'd11:   div = DIV_W'(50619);
            default: div = '0;
        endcase
        return div;
    endfunction

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        base_d       = base_q;
        clkdivider_d = clkdivider_q;
        note_code_d  = note_code_q;
        beats_d      = beats_q;
        tick_d       = tick_q;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d    = S_FETCH;
                    rom_addr_d = song_base;
                    base_d     = song_base;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (rom_data[3:0] == CODE_END) begin
                    if (loop) begin
                        rom_addr_d = base_q;
                        state_d    = S_FETCH;
                    end else begin
                        clkdivider_d = '0;
                        note_code_d  = CODE_SILENT;
                        state_d      = S_DONE;
                    end
                end else begin
                    // Rests share the PLAY timing but get a zero divider
                    clkdivider_d = note_div(rom_data[3:0]);
                    note_code_d  = (rom_data[3:0] >= CODE_SILENT) ? CODE_SILENT : rom_data[3:0];
                    beats_d      = rom_data[5:4];
                    tick_d       = BEAT_RELOAD;
                    state_d      = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick_q == '0) begin
                    if (beats_q == 2'd0) begin
                        clkdivider_d = '0;
                        note_code_d  = CODE_SILENT;
                        tick_d       = GAP_RELOAD;
                        state_d      = S_GAP;
                    end else begin
                        beats_d = beats_q - 2'd1;
                        tick_d  = BEAT_RELOAD;
                    end
                end else begin
                    tick_d = tick_q - TICK_ONE;
                end
            end
            S_GAP: begin
                if (tick_q == '0) begin
                    rom_addr_d = rom_addr_q + ADDR_ONE;
                    state_d    = S_FETCH;
                end else begin
                    tick_d = tick_q - TICK_ONE;
                end
            end
            S_DONE: begin
                clkdivider_d = '0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // stop overrides every transition above; no done pulse on abort
        if (stop && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            clkdivider_d = '0;
            note_code_d  = CODE_SILENT;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rom_addr_q   <= '0;
            base_q       <= '0;
            clkdivider_q <= '0;
            note_code_q  <= CODE_SILENT;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            beats_q      <= '0;
            tick_q       <= '0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            base_q       <= base_d;
            clkdivider_q <= clkdivider_d;
            note_code_q  <= note_code_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            beats_q      <= beats_d;
            tick_q       <= tick_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign clkdivider = clkdivider_q;
    assign note_code  = note_code_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_song_sequencer_ctrl.sv
// Scoreboard bench for song_sequencer_ctrl: output segments (divider, note, length)
// and fetch addresses are predicted from ROM contents and compared as they appear.
module tb_song_sequencer_ctrl;

    localparam int T      = 4;
    localparam int G      = 1;
    localparam int ADDR_W = 8;
    localparam int DIV_W  = 26;

    typedef struct packed {
        logic [25:0] div;
        logic [3:0]  note;
        logic [15:0] len;
    } seg_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic              stop;
    logic              loop;
    logic [ADDR_W-1:0] song_base;
    logic [ADDR_W-1:0] rom_addr;
    logic [5:0]        rom_data;
    logic [DIV_W-1:0]  clkdivider;
    logic [3:0]        note_code;
    logic              busy;
    logic              done;

    logic [5:0] rom [256];
    int div_tab [12] = '{95556, 90194, 85131, 80353, 75843, 71586,
                         67568, 63776, 60197, 56818, 53629, 50619};

    seg_t              exp_seg [$];
    logic [ADDR_W-1:0] exp_addr [$];

    int n_total = 0;
    int n_bad   = 0;
    int done_cnt = 0;
    bit sb_en = 0;

    song_sequencer_ctrl #(
        .TICKS_PER_BEAT(T),
        .GAP_TICKS     (G),
        .ADDR_W        (ADDR_W),
        .DIV_W         (DIV_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .song_base (song_base),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .clkdivider(clkdivider),
        .note_code (note_code),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic push_seg(input int d, input int n, input int len);
        seg_t s;
        s.div  = 26'(d);
        s.note = 4'(n);
        s.len  = 16'(len);
        exp_seg.push_back(s);
    endtask

    // Predict output segments from the spec timing: FETCH+LOAD = 2 silent cycles,
    // a note holds beats*T, GAP holds G, DONE adds one final silent busy cycle.
    task automatic expect_song(input logic [7:0] base, input int passes);
        int z;
        int b;
        logic [7:0] a;
        logic [5:0] w;
        z = 2;
        for (int p = 0; p < passes; p++) begin
            a = base;
            for (int k = 0; k < 256; k++) begin
                exp_addr.push_back(a);
                w = rom[a];
                b = int'(w[5:4]) + 1;
                if (w[3:0] == 4'd15) break;
                if (w[3:0] >= 4'd12) begin
                    z += b * T + G + 2;
                end else begin
                    push_seg(0, 12, z);
                    push_seg(div_tab[w[3:0]], int'(w[3:0]), b * T);
                    z = G + 2;
                end
                a = a + 8'd1;
            end
            if (p < passes - 1) z += 2;
        end
        push_seg(0, 12, z + 1);
    endtask

    // Monitor: segments of constant (divider, note) while busy, fetch addresses, done pulses
    logic [DIV_W-1:0]  cur_div;
    logic [3:0]        cur_note;
    int                cur_len;
    bit                in_seg = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    int                since_addr = 100;
    logic              done_prev = 1'b0;

    task automatic emit_seg();
        seg_t got;
        seg_t want;
        got.div  = cur_div;
        got.note = cur_note;
        got.len  = 16'(cur_len);
        chk("seg_pending", 64'(exp_seg.size() != 0), 64'd1);
        if (exp_seg.size() != 0) begin
            want = exp_seg.pop_front();
            chk("seg", 64'(got), 64'(want));
        end
    endtask

    always @(negedge clk) begin
        if (!sb_en) begin
            in_seg = 0;
        end else begin
            if (busy) begin
                if (in_seg && clkdivider == cur_div && note_code == cur_note) begin
                    cur_len++;
                end else begin
                    if (in_seg) emit_seg();
                    cur_div  = clkdivider;
                    cur_note = note_code;
                    cur_len  = 1;
                    in_seg   = 1;
                end
            end else if (in_seg) begin
                emit_seg();
                in_seg = 0;
            end
            if (busy && rom_addr != last_addr) begin
                chk("addr_pending", 64'(exp_addr.size() != 0), 64'd1);
                if (exp_addr.size() != 0) chk("addr", 64'(rom_addr), 64'(exp_addr.pop_front()));
            end
        end
        if (rom_addr != last_addr) since_addr = 0;
        else since_addr++;
        last_addr = rom_addr;
        if (done) begin
            done_cnt++;
            chk("done_latency", 64'(since_addr), 64'd2);
            chk("done_width", 64'(done_prev), 64'd0);
        end
        done_prev = done;
    end

    task automatic play(input logic [7:0] base);
        @(negedge clk);
        song_base = base;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    task automatic wait_tone(input int max_cyc);
        int n;
        n = 0;
        while (clkdivider == '0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_song(input string name, input logic [7:0] base);
        int d0;
        d0 = done_cnt;
        expect_song(base, 1);
        play(base);
        chk({name, "_busy"}, 64'(busy), 64'd1);
        wait_idle(300);
        chk({name, "_segs_left"}, 64'(exp_seg.size()), 64'd0);
        chk({name, "_addr_left"}, 64'(exp_addr.size()), 64'd0);
        chk({name, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0;
        int hits;
        int n;
        logic [7:0] prev;

        reset     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        loop      = 1'b0;
        song_base = '0;
        for (int i = 0; i < 256; i++) rom[i] = 6'h0F;
        rom[8'h10] = 6'h02;
        rom[8'h20] = 6'h39;
        rom[8'h21] = 6'h0C;
        rom[8'h30] = 6'h10;
        rom[8'h31] = 6'h04;
        rom[8'h40] = 6'h3B;
        rom[8'h50] = 6'h27;
        rom[8'hFF] = 6'h01;
        rom[8'h00] = 6'h05;

        repeat (3) @(negedge clk);
        chk("rst_addr", 64'(rom_addr), 64'd0);
        chk("rst_div", 64'(clkdivider), 64'd0);
        chk("rst_note", 64'(note_code), 64'd12);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        sb_en = 1;
        repeat (2) @(negedge clk);

        run_song("basic", 8'h10);
        run_song("rest", 8'h20);

        // loop for two passes, then drop loop so the third pass ends
        d0 = done_cnt;
        loop = 1'b1;
        expect_song(8'h30, 3);
        play(8'h30);
        hits = 1;
        n = 0;
        prev = rom_addr;
        while (hits < 3 && n < 300) begin
            @(negedge clk);
            n++;
            if (rom_addr == 8'h30 && prev != 8'h30) hits++;
            prev = rom_addr;
        end
        chk("loop_rewinds", 64'(hits), 64'd3);
        chk("loop_no_done", 64'(done_cnt - d0), 64'd0);
        loop = 1'b0;
        wait_idle(300);
        chk("loop_segs_left", 64'(exp_seg.size()), 64'd0);
        chk("loop_addr_left", 64'(exp_addr.size()), 64'd0);
        chk("loop_done_cnt", 64'(done_cnt - d0), 64'd1);

        // stop mid-note
        sb_en = 0;
        play(8'h40);
        wait_tone(50);
        chk("stop_tone", 64'(clkdivider), 64'd50619);
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        stop = 1'b1;
        @(posedge clk);
        #1;
        chk("stop_busy", 64'(busy), 64'd0);
        chk("stop_div", 64'(clkdivider), 64'd0);
        chk("stop_note", 64'(note_code), 64'd12);
        chk("stop_done", 64'(done), 64'd0);
        @(negedge clk);
        stop = 1'b0;
        repeat (5) @(negedge clk);
        chk("stop_no_done", 64'(done_cnt - d0), 64'd0);

        // start and stop together: stop wins
        @(negedge clk);
        song_base = 8'h50;
        start     = 1'b1;
        stop      = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("startstop_busy", 64'(busy), 64'd0);
        end
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);

        // start with a different base while busy is ignored
        sb_en = 1;
        d0 = done_cnt;
        expect_song(8'h50, 1);
        play(8'h50);
        repeat (5) @(negedge clk);
        song_base = 8'h10;
        start     = 1'b1;
        repeat (2) @(negedge clk);
        start     = 1'b0;
        wait_idle(300);
        chk("busystart_segs_left", 64'(exp_seg.size()), 64'd0);
        chk("busystart_addr_left", 64'(exp_addr.size()), 64'd0);
        chk("busystart_done_cnt", 64'(done_cnt - d0), 64'd1);

        // asynchronous reset between edges
        sb_en = 0;
        play(8'h40);
        wait_tone(50);
        chk("areset_tone", 64'(clkdivider), 64'd50619);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_addr", 64'(rom_addr), 64'd0);
        chk("areset_div", 64'(clkdivider), 64'd0);
        chk("areset_note", 64'(note_code), 64'd12);
        chk("areset_busy", 64'(busy), 64'd0);
        chk("areset_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        sb_en = 1;

        run_song("wrap", 8'hFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
